// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit restoring divider, 32 steps per divide; define DIV_SIGNED_EN for signed (div) semantics, else unsigned (divu).
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        DIVCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        DIVOut,
  output logic        divZero
);

  typedef enum logic [2:0] {IDLE, CALC, DONE, ZERO, HOLD} state_t;

  state_t      state;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [32:0] rem;
  logic [4:0]  count;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic        q_bit;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  // dvd shifts dividend bits out at the top and quotient bits in at the bottom
  always_comb begin
    shifted  = {rem[31:0], dvd[31]};
    trial    = shifted - {1'b0, dvs};
    q_bit    = ~trial[32];
    rem_next = q_bit ? trial : shifted;
    quo_next = {dvd[30:0], q_bit};
`ifdef DIV_SIGNED_EN
    a_mag   = A[31] ? -A : A;
    b_mag   = B[31] ? -B : B;
    quo_fix = neg_q ? -quo_next : quo_next;
    rem_fix = neg_r ? -rem_next[31:0] : rem_next[31:0];
`else
    a_mag   = A;
    b_mag   = B;
    quo_fix = quo_next;
    rem_fix = rem_next[31:0];
`endif
  end

  assign DIVOut  = (state == DONE);
  assign divZero = (state == ZERO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      count <= '0;
      HI    <= '0;
      LO    <= '0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (DIVCtrl) begin
            if (B == 32'd0) begin
              state <= ZERO;
            end else begin
              dvd   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              count <= '0;
`ifdef DIV_SIGNED_EN
              neg_q <= A[31] ^ B[31];
              neg_r <= A[31];
`endif
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!DIVCtrl) begin
            state <= IDLE;
          end else begin
            rem   <= rem_next;
            dvd   <= quo_next;
            count <= count + 5'd1;
            if (count == 5'd31) begin
              LO    <= quo_fix;
              HI    <= rem_fix;
              state <= DONE;
            end
          end
        end
        DONE, ZERO: state <= DIVCtrl ? HOLD : IDLE;
        HOLD: begin
          if (!DIVCtrl) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        DIVCtrl = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DIVOut;
  logic        divZero;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  div_unit dut (
    .clk(clk), .reset(reset), .DIVCtrl(DIVCtrl), .A(A), .B(B),
    .HI(HI), .LO(LO), .DIVOut(DIVOut), .divZero(divZero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
`ifdef DIV_SIGNED_EN
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    q = 32'(sa / sb);
    r = 32'(sa % sb);
`else
    q = a / b;
    r = a % b;
`endif
  endfunction

  // Starts from IDLE, checks the full handshake and result, returns to IDLE.
  task automatic do_divide(input logic [31:0] a, input logic [31:0] b, input int hold,
                           input bit scramble, input string name);
    logic [31:0] eq;
    logic [31:0] er;
    int early;
    int bad_hold;
    ref_div(a, b, eq, er);
    A = a;
    B = b;
    DIVCtrl = 1'b1;
    tick();
    if (scramble) begin
      A = $urandom;
      B = $urandom;
    end
    early = 0;
    for (int k = 1; k <= 32; k++) begin
      if (DIVOut !== 1'b0 || divZero !== 1'b0 || HI !== exp_hi || LO !== exp_lo) early++;
      tick();
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL %s_early: %0d busy cycles with a pulse or HI/LO change, expected 0", name, early);
    end
    tests++;
    if (DIVOut !== 1'b1 || divZero !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: DIVOut=%b divZero=%b at cycle 33, expected 1 0", name, DIVOut, divZero);
    end
    tests++;
    if (LO !== eq || HI !== er) begin
      fails++;
      $display("FAIL %s_result: %h/%h LO=%h HI=%h, expected LO=%h HI=%h", name, a, b, LO, HI, eq, er);
    end
    exp_lo = eq;
    exp_hi = er;
    bad_hold = 0;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (DIVOut !== 1'b0 || divZero !== 1'b0 || HI !== exp_hi || LO !== exp_lo) bad_hold++;
    end
    DIVCtrl = 1'b0;
    tick();
    tests++;
    if (bad_hold != 0 || DIVOut !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      fails++;
      $display("FAIL %s_hold: %0d bad held cycles, DIVOut=%b after release, expected 0 0", name, bad_hold, DIVOut);
    end
  endtask

  task automatic test_reset();
    DIVCtrl = 1'b1;
    A = 32'd9;
    B = 32'd3;
    #2;
    tests++;
    if (HI !== 32'd0 || LO !== 32'd0 || DIVOut !== 1'b0 || divZero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: HI=%h LO=%h DIVOut=%b divZero=%b, expected all 0", HI, LO, DIVOut, divZero);
    end
    for (int k = 0; k < 40; k++) tick();
    tests++;
    if (HI !== 32'd0 || LO !== 32'd0 || DIVOut !== 1'b0) begin
      fails++;
      $display("FAIL reset_held: HI=%h LO=%h DIVOut=%b under reset, expected 0", HI, LO, DIVOut);
    end
    DIVCtrl = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    do_divide(32'd100, 32'd7, 5, 1'b0, "nominal");
    tests++;
    if (LO !== 32'd14 || HI !== 32'd2) begin
      fails++;
      $display("FAIL nominal_const: LO=%0d HI=%0d, expected 14 2", LO, HI);
    end
  endtask

  task automatic test_signed();
    do_divide(32'hFFFF_FFF9, 32'd2, 0, 1'b0, "neg_dividend");
    do_divide(32'd7, 32'hFFFF_FFFE, 1, 1'b0, "neg_divisor");
    do_divide(32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0, "overflow");
`ifdef DIV_SIGNED_EN
    tests++;
    if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
      fails++;
      $display("FAIL overflow_const: LO=%h HI=%h, expected 80000000 00000000", LO, HI);
    end
`else
    tests++;
    if (LO !== 32'd0 || HI !== 32'h8000_0000) begin
      fails++;
      $display("FAIL overflow_const: LO=%h HI=%h, expected 00000000 80000000", LO, HI);
    end
`endif
  endtask

  task automatic test_div_zero();
    int seen_done;
    A = 32'd5;
    B = 32'd0;
    DIVCtrl = 1'b1;
    tick();
    tests++;
    if (divZero !== 1'b1 || DIVOut !== 1'b0) begin
      fails++;
      $display("FAIL divzero_pulse: divZero=%b DIVOut=%b, expected 1 0", divZero, DIVOut);
    end
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (divZero !== 1'b0 || DIVOut !== 1'b0) seen_done++;
    end
    tests++;
    if (seen_done != 0 || HI !== exp_hi || LO !== exp_lo) begin
      fails++;
      $display("FAIL divzero_after: %0d extra pulses, HI=%h LO=%h, expected 0 %h %h", seen_done, HI, LO, exp_hi, exp_lo);
    end
    DIVCtrl = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int pulses;
    A = 32'd100;
    B = 32'd7;
    DIVCtrl = 1'b1;
    tick();
    for (int k = 1; k <= 9; k++) tick();
    DIVCtrl = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (DIVOut !== 1'b0 || divZero !== 1'b0) pulses++;
    end
    tests++;
    if (pulses != 0 || HI !== exp_hi || LO !== exp_lo) begin
      fails++;
      $display("FAIL abort: %0d pulses, HI=%h LO=%h, expected 0 %h %h", pulses, HI, LO, exp_hi, exp_lo);
    end
    do_divide(32'd100, 32'd7, 0, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid();
    A = 32'd1000;
    B = 32'd3;
    DIVCtrl = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) tick();
    reset = 1'b0;
    #1;
    tests++;
    if (HI !== 32'd0 || LO !== 32'd0 || DIVOut !== 1'b0 || divZero !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: HI=%h LO=%h DIVOut=%b divZero=%b, expected all 0", HI, LO, DIVOut, divZero);
    end
    exp_hi = '0;
    exp_lo = '0;
    tick();
    tick();
    reset = 1'b1;
    do_divide(32'd12345, 32'd17, 1, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_divide(32'hFFFF_FFFF, 32'd1, 0, 1'b0, "b2b_div1");
    do_divide(32'd0, 32'd9, 0, 1'b0, "b2b_zero_dividend");
    do_divide(32'd6, 32'd7, 0, 1'b0, "b2b_small");
    do_divide(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "b2b_equal");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = -($urandom_range(1, 1000));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (b == 32'd0) b = 32'd1;
      do_divide(a, b, $urandom_range(0, 3), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_signed();
    test_div_zero();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, system clock; all state updates on the rising edge.
REQ-002 The block SHALL have port `reset`: input, 1 bit; reset is asynchronous and active-low.
REQ-003 The block SHALL have port `DIVCtrl`: input, 1 bit, level request from the control unit; held high for the whole divide.
REQ-004 The block SHALL have port `A`: input, 32 bits, dividend (rs).
REQ-005 The block SHALL have port `B`: input, 32 bits, divisor (rt).
REQ-006 The block SHALL have port `HI`: output, 32 bits, registered remainder.
REQ-007 The block SHALL have port `LO`: output, 32 bits, registered quotient.
REQ-008 The block SHALL have port `DIVOut`: output, 1 bit, one-cycle done pulse; HI/LO valid when it is high.
REQ-009 The block SHALL have port `divZero`: output, 1 bit, one-cycle divide-by-zero pulse.

Function
REQ-010 The block SHALL implement a Moore FSM with states IDLE, CALC, DONE, ZERO and HOLD.
REQ-011 IDLE: on the edge that samples DIVCtrl=1:
- B==0 -> go to ZERO.
- Otherwise -> latch |A|, |B| and the sign bits, clear the 33-bit partial remainder, clear the 5-bit count, go to CALC.
REQ-012 A and B SHALL be sampled only at the start edge; later changes SHALL be ignored.
REQ-013 CALC SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit per step, MSB first.
REQ-014 CALC SHALL do exactly 32 steps; on the edge completing step 32 (count==31) it SHALL go to DONE.
REQ-015 On that same edge, LO and HI SHALL be written with the sign-corrected quotient and remainder.
REQ-016 Latency: DIVOut SHALL be high during the 33rd cycle after the start edge, for exactly one cycle.
REQ-017 Signed results SHALL follow these rules:
- Quotient truncates toward zero.
- Remainder takes the dividend's sign.
- 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 with no exception.
REQ-018 ZERO SHALL assert divZero for one cycle, keep DIVOut=0, and leave HI/LO unchanged.
REQ-019 From DONE or ZERO, the next edge SHALL go to HOLD if DIVCtrl=1, else to IDLE.
REQ-020 HOLD SHALL stay until DIVCtrl=0, then go to IDLE; a held request SHALL never restart a divide.
REQ-021 DIVCtrl=0 sampled in CALC SHALL abort to IDLE, leave HI/LO unchanged, and produce no DIVOut pulse.
REQ-022 DIVOut and divZero SHALL be decoded from state only, be mutually exclusive, and be registered-state glitch-free.
REQ-023 HI/LO SHALL change only on the DONE-entry edge or on reset.

Reset
REQ-024 reset low SHALL immediately force:
- state=IDLE
- HI=0, LO=0
- DIVOut=0, divZero=0
- count=0
- internal operand and remainder registers=0
REQ-025 Reset asserted mid-CALC SHALL discard the operation; after release the block SHALL wait in IDLE for a new DIVCtrl sample.
REQ-026 Reset release SHALL take effect on the first clk edge after reset goes high.

Configuration
REQ-027 Macro DIV_SIGNED_EN defined: the block SHALL perform signed (MIPS div) semantics per REQ-017.
REQ-028 Macro DIV_SIGNED_EN undefined: the block SHALL perform unsigned semantics (divu):
- No absolute value or sign correction.
- 0x80000000 / 0xFFFFFFFF SHALL give LO=0, HI=0x80000000.
- Latency and handshake SHALL be identical to the signed build.

Verification
REQ-029 Nominal divide: A=100, B=7, DIVCtrl held high -> DIVOut high exactly 33 cycles after the start edge, LO=14, HI=2, then HOLD until DIVCtrl drops.
REQ-030 Signed divide (DIV_SIGNED_EN): A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-031 Divide by zero: A=5, B=0 -> divZero high for one cycle on the cycle after the start edge, DIVOut never high, HI/LO keep their prior values.
REQ-032 Overflow with DIV_SIGNED_EN: A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; the same stimulus in the unsigned build -> LO=0, HI=0x80000000.
REQ-033 Abort: start A=100, B=7, drop DIVCtrl at cycle 10 -> return to IDLE, no DIVOut, HI/LO unchanged; a new request then completes normally in 33 cycles.
REQ-034 Reset mid-operation: assert reset at cycle 20 of CALC -> HI=LO=0 and outputs low immediately; with DIVCtrl still high after release, a fresh divide starts and completes correctly.
